vga_rom_arbiter: RTL and testbench
==================================

Name: vga_rom_arbiter

Overview:
Shares the single synchronous pattern ROM between two readers. Port 0 is the VGA pixel pipeline (task2-style address generator). It has strict priority and a fixed, never-stalled latency. Port 1 is a background reader (sprite loader / checksum engine) using a req/ack handshake that is served only in cycles where port 0 does not request. The block sits between the address generators and the ROM, and routes returned data back to the owner with a tag pipeline.

Parameters:
AW, 11, ROM address width
DW, 8, ROM data width
ROM_LAT, 1, ROM read latency in cycles from rom_addr to rom_data (legal 1..3)
STARVE_LIMIT, 1023, consecutive port-1 pending cycles before starvation flag (legal 1..65535)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
m0_req  in  1  port 0 read request, sampled every cycle
m0_addr  in  AW  port 0 address
m0_valid  out  1  port 0 data valid, one cycle per granted request
m0_data  out  DW  port 0 read data
m1_req  in  1  port 1 request; held with stable m1_addr until m1_ack
m1_addr  in  AW  port 1 address
m1_ack  out  1  one-cycle pulse: port 1 request accepted
m1_valid  out  1  one-cycle pulse: port 1 data valid
m1_data  out  DW  port 1 read data, held until next m1_valid
m1_starve  out  1  sticky starvation flag
rom_addr  out  AW  registered ROM address
rom_data  in  DW  ROM read data

Behaviour:
- Reset, synchronous, rst=1 at a clk edge:
  - rom_addr=0, m0_valid=0, m0_data=0, m1_ack=0, m1_valid=0, m1_data=0, m1_starve=0.
  - Tag pipeline = NONE; FSM = IDLE; starve counter = 0.
  - Requests in flight at reset are discarded: no valid pulse may appear after reset deasserts.
- Grant, evaluated in cycle n:
  - m0_req=1: rom_addr<=m0_addr, tag M0. Port 0 always wins, including same-cycle contention.
  - Else, if m1_req=1 and FSM in IDLE or PEND: rom_addr<=m1_addr, tag M1, m1_ack=1 in cycle n+1, FSM->RESP.
  - Else: rom_addr holds its value, tag NONE (no ROM cycle is counted as a read).
- Tag pipeline: ROM_LAT+1 stages of {NONE, M0, M1}. Stage 0 is loaded alongside rom_addr.
- Return: rom_data is valid in cycle n+1+ROM_LAT. It is registered into the output selected by the tag. The valid output is high in cycle n+2+ROM_LAT (total latency L=ROM_LAT+2; 3 cycles at default).
- Port 0 guarantees:
  - Back-to-back requests give back-to-back m0_valid, in order, with no bubbles.
  - m0_data holds its last value when m0_valid=0.
- Port 1 FSM:
  - IDLE: m1_req=1 and m0_req=1 -> PEND; m1_req=1 and m0_req=0 -> grant, go to RESP.
  - PEND: m0_req=1 -> stay, starve counter +1 (saturating); m0_req=0 -> grant, go to RESP; m1_req=0 (requester abort) -> IDLE, no ack.
  - RESP: m1_req is ignored. Exactly one outstanding port-1 read. On m1_valid -> IDLE.
  - The requester may re-assert in the cycle after m1_valid.
- Starve counter:
  - Cleared on grant and on entering IDLE.
  - m1_starve is set when the counter reaches STARVE_LIMIT and stays set until rst.
- m1_ack and m1_valid never coincide (ROM_LAT>=1).
- No combinational path from any input to any output.

Test Plan:
1. rst=1 for 3 cycles while m0_req=1 and m1_req=1 -> all outputs 0, rom_addr=0; first m0_valid exactly 3 cycles after rst drops.
2. ROM model data=addr[7:0]^8'h5A, ROM_LAT=1; m0 streams 0x000..0x00F on 16 consecutive cycles -> m0_valid high 16 consecutive cycles starting at n+3, m0_data=0x5A,0x5B,... in order.
3. m1 alone, m1_addr=0x123 at cycle n -> m1_ack at n+1, m1_valid at n+3, m1_data=0x79; m0_valid stays 0.
4. m1_req=0x045 asserted during a 20-cycle m0 burst -> m1_ack one cycle after the burst ends; every m0 result unchanged and gapless; m1_data=0x1F.
5. STARVE_LIMIT=8, m0 continuous for 12 cycles with m1 pending -> m1_starve rises after 8 pending cycles and stays 1 after the grant and to end of test.
6. rst pulsed for 1 cycle the cycle after m1_ack -> no m1_valid ever appears; FSM IDLE; a fresh m1 request completes normally.

Source files
------------

// File: rtl/vga_rom_arbiter.sv
// Two-port arbiter in front of the synchronous pattern ROM. Port 0 (pixel pipe) has
// strict priority and fixed latency; port 1 (background reader) is served with req/ack in idle cycles.
module vga_rom_arbiter #(
    parameter int AW           = 11,
    parameter int DW           = 8,
    parameter int ROM_LAT      = 1,
    parameter int STARVE_LIMIT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_valid,
    output logic [DW-1:0] m0_data,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    output logic          m1_ack,
    output logic          m1_valid,
    output logic [DW-1:0] m1_data,
    output logic          m1_starve,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data
);

    localparam int            CW        = 16;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_M0   = 2'd1,
        TAG_M1   = 2'd2
    } tag_e;

    state_e        state_q, state_d;
    tag_e          tag_q [0:ROM_LAT];
    tag_e          tag_d [0:ROM_LAT];
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          m0_valid_q, m0_valid_d;
    logic [DW-1:0] m0_data_q, m0_data_d;
    logic          m1_ack_q, m1_ack_d;
    logic          m1_valid_q, m1_valid_d;
    logic [DW-1:0] m1_data_q, m1_data_d;
    logic          starve_q, starve_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_m0_s;
    logic          grant_m1_s;

    // Grant decision, ROM address and tag-pipeline advance.
    always_comb begin
        grant_m0_s = m0_req;
        grant_m1_s = !m0_req && m1_req && ((state_q == ST_IDLE) || (state_q == ST_PEND));
        rom_addr_d = rom_addr_q;
        tag_d[0]   = TAG_NONE;
        if (grant_m0_s) begin
            rom_addr_d = m0_addr;
            tag_d[0]   = TAG_M0;
        end else if (grant_m1_s) begin
            rom_addr_d = m1_addr;
            tag_d[0]   = TAG_M1;
        end else begin
            rom_addr_d = rom_addr_q;
            tag_d[0]   = TAG_NONE;
        end
        for (int k = 1; k <= ROM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        m1_ack_d = grant_m1_s;
    end

    // Returned ROM data is steered to the owner named by the last tag stage.
    always_comb begin
        m0_valid_d = 1'b0;
        m0_data_d  = m0_data_q;
        m1_valid_d = 1'b0;
        m1_data_d  = m1_data_q;
        case (tag_q[ROM_LAT])
            TAG_M0: begin
                m0_valid_d = 1'b1;
                m0_data_d  = rom_data;
            end
            TAG_M1: begin
                m1_valid_d = 1'b1;
                m1_data_d  = rom_data;
            end
            default: begin
                m0_valid_d = 1'b0;
                m1_valid_d = 1'b0;
            end
        endcase
    end

    // Port-1 handshake FSM and starvation counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (m1_req && m0_req) begin
                    state_d = ST_PEND;
                end else if (grant_m1_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (!m1_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (m0_req) begin
                    state_d = ST_PEND;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
                end else begin
                    state_d = ST_RESP;
                    cnt_d   = {CW{1'b0}};
                end
            end
            ST_RESP: begin
                // Exactly one read outstanding; the request line is ignored here.
                if (m1_valid_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        starve_d = starve_q || (cnt_d >= STARVE_LIM);
    end

    // State registers; reset also flushes in-flight tags so no stale valid escapes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= {AW{1'b0}};
            m0_valid_q <= 1'b0;
            m0_data_q  <= {DW{1'b0}};
            m1_ack_q   <= 1'b0;
            m1_valid_q <= 1'b0;
            m1_data_q  <= {DW{1'b0}};
            starve_q   <= 1'b0;
            cnt_q      <= {CW{1'b0}};
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= TAG_NONE;
            end
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            m0_valid_q <= m0_valid_d;
            m0_data_q  <= m0_data_d;
            m1_ack_q   <= m1_ack_d;
            m1_valid_q <= m1_valid_d;
            m1_data_q  <= m1_data_d;
            starve_q   <= starve_d;
            cnt_q      <= cnt_d;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign m0_valid  = m0_valid_q;
    assign m0_data   = m0_data_q;
    assign m1_ack    = m1_ack_q;
    assign m1_valid  = m1_valid_q;
    assign m1_data   = m1_data_q;
    assign m1_starve = starve_q;

endmodule

// File: tb/tb_vga_rom_arbiter.sv
// Directed bench for vga_rom_arbiter: ROM model returns addr[7:0]^8'h5A after one cycle.
module tb_vga_rom_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_valid;
    logic [DW-1:0] m0_data;
    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic          m1_ack;
    logic          m1_valid;
    logic [DW-1:0] m1_data;
    logic          m1_starve;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = 8'h00;

    int passed = 0;
    int total  = 0;

    vga_rom_arbiter #(
        .AW(AW), .DW(DW), .ROM_LAT(1), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_valid(m0_valid), .m0_data(m0_data),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_ack(m1_ack), .m1_valid(m1_valid),
        .m1_data(m1_data), .m1_starve(m1_starve),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'h5A;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [7:0] e;
        // 1: reset with both requesters active
        rst = 1'b1; m0_req = 1'b1; m0_addr = 11'h010; m1_req = 1'b1; m1_addr = 11'h020;
        tick(); tick(); tick();
        check("rst_m0_valid", 32'(m0_valid), 32'd0);
        check("rst_m0_data", 32'(m0_data), 32'd0);
        check("rst_m1_ack", 32'(m1_ack), 32'd0);
        check("rst_m1_valid", 32'(m1_valid), 32'd0);
        check("rst_m1_data", 32'(m1_data), 32'd0);
        check("rst_starve", 32'(m1_starve), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0; m1_req = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            check("t1_m0_valid", 32'(m0_valid), 32'(i == 3));
            if (i == 3) check("t1_m0_data", 32'(m0_data), 32'h4A);
            m0_req = (i == 0); m0_addr = 11'h010;
            tick();
        end

        // 2: 16-address stream, gapless in-order results
        for (int i = 0; i <= 20; i++) begin
            check("t2_m0_valid", 32'(m0_valid), 32'(i >= 3 && i <= 18));
            check("t2_m1_valid", 32'(m1_valid), 32'd0);
            e = 8'(i - 3) ^ 8'h5A;
            if (i >= 3 && i <= 18) check("t2_m0_data", 32'(m0_data), 32'(e));
            if (i > 18) check("t2_m0_hold", 32'(m0_data), 32'h55);
            m0_req = (i < 16); m0_addr = AW'(i);
            tick();
        end

        // 3: port 1 alone
        for (int i = 0; i <= 5; i++) begin
            check("t3_m1_ack", 32'(m1_ack), 32'(i == 1));
            check("t3_m1_valid", 32'(m1_valid), 32'(i == 3));
            check("t3_m0_valid", 32'(m0_valid), 32'd0);
            if (i >= 3) check("t3_m1_data", 32'(m1_data), 32'h79);
            m1_req = (i == 0); m1_addr = 11'h123;
            tick();
        end

        // 5: starvation with limit 8 during a 12-cycle port-0 burst
        for (int i = 0; i <= 17; i++) begin
            check("t5_starve", 32'(m1_starve), 32'(i >= 9));
            check("t5_m1_ack", 32'(m1_ack), 32'(i == 13));
            check("t5_m1_valid", 32'(m1_valid), 32'(i == 15));
            check("t5_m0_valid", 32'(m0_valid), 32'(i >= 3 && i <= 14));
            e = 8'(i - 3) ^ 8'h5A;
            if (i >= 3 && i <= 14) check("t5_m0_data", 32'(m0_data), 32'(e));
            if (i >= 15) check("t5_m1_data", 32'(m1_data), 32'hF0);
            m0_req = (i < 12); m0_addr = AW'(11'h100 + i);
            m1_req = (i < 13); m1_addr = 11'h0AA;
            tick();
        end

        // 4: port 1 waits out a 20-cycle port-0 burst
        for (int i = 0; i <= 24; i++) begin
            check("t4_m0_valid", 32'(m0_valid), 32'(i >= 3 && i <= 22));
            e = 8'(i - 3) ^ 8'h5A;
            if (i >= 3 && i <= 22) check("t4_m0_data", 32'(m0_data), 32'(e));
            check("t4_m1_ack", 32'(m1_ack), 32'(i == 21));
            check("t4_m1_valid", 32'(m1_valid), 32'(i == 23));
            if (i >= 23) check("t4_m1_data", 32'(m1_data), 32'h1F);
            check("t4_starve", 32'(m1_starve), 32'd1);
            m0_req = (i < 20); m0_addr = AW'(11'h200 + i);
            m1_req = (i < 21); m1_addr = 11'h045;
            tick();
        end

        // 6: reset the cycle after ack discards the read
        for (int i = 0; i <= 6; i++) begin
            check("t6_m1_valid", 32'(m1_valid), 32'd0);
            if (i == 1) check("t6_m1_ack", 32'(m1_ack), 32'd1);
            if (i >= 2) check("t6_starve", 32'(m1_starve), 32'd0);
            if (i >= 2) check("t6_m1_data", 32'(m1_data), 32'd0);
            rst = (i == 1); m1_req = (i == 0); m1_addr = 11'h077;
            tick();
        end
        for (int i = 0; i <= 5; i++) begin
            check("t6b_m1_ack", 32'(m1_ack), 32'(i == 1));
            check("t6b_m1_valid", 32'(m1_valid), 32'(i == 3));
            if (i >= 3) check("t6b_m1_data", 32'(m1_data), 32'hAA);
            m1_req = (i == 0); m1_addr = 11'h0F0;
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
